// File: rtl/processador_pkg.sv
// processador_pkg
// Shared definitions for the instruction-fetch front end:
//   - estado_t : program-counter FSM states
//   - ADDR_W   : instruction address width
//   - MUX_*    : control encodings of the next-address mux feeding the PC
//   - incrementa_endereco : sequential next address (carry discarded)
package processador_pkg;

    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        EXECUTANDO = 2'b00,
        DRENANDO   = 2'b01,
        TROCANDO   = 2'b10,
        PARADO     = 2'b11
    } estado_t;

    // Next-address mux select encodings
    localparam logic [1:0] MUX_DESVIO     = 2'b11;
    localparam logic [1:0] MUX_MANTEM     = 2'b10;
    localparam logic [1:0] MUX_ZERO       = 2'b01;
    localparam logic [1:0] MUX_SEQUENCIAL = 2'b00;

    // Wraps 32'hFFFF_FFFF to 0
    function automatic logic [ADDR_W-1:0] incrementa_endereco(input logic [ADDR_W-1:0] endereco);
        return endereco + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/tabela_contexto.sv
// tabela_contexto
// Per-process saved-PC register file.
// Ports:
//   clock, reset              : clock and synchronous active-high clear of all slots
//   salva_en/_id/_dado        : context-save write (from the switch cycle)
//   escreve_en/_id/_dado      : initial-PC write from the OS
//   le_id / le_dado           : asynchronous read port
// When both writes target the same slot the context save wins; writes to
// different slots complete in the same cycle. Reads see pre-edge contents.
module tabela_contexto
    import processador_pkg::*;
#(
    parameter int NUM_PROCESSOS = 8,
    parameter int PID_W         = $clog2(NUM_PROCESSOS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              salva_en,
    input  logic [PID_W-1:0]  salva_id,
    input  logic [ADDR_W-1:0] salva_dado,
    input  logic              escreve_en,
    input  logic [PID_W-1:0]  escreve_id,
    input  logic [ADDR_W-1:0] escreve_dado,
    input  logic [PID_W-1:0]  le_id,
    output logic [ADDR_W-1:0] le_dado
);

    logic [ADDR_W-1:0] slots [NUM_PROCESSOS];

    generate
        for (genvar gi = 0; gi < NUM_PROCESSOS; gi++) begin : g_slot
            logic [ADDR_W-1:0] slot_reg;
            logic              salva_aqui;
            logic              escreve_aqui;

            assign salva_aqui   = salva_en   && (salva_id   == PID_W'(gi));
            assign escreve_aqui = escreve_en && (escreve_id == PID_W'(gi));

            always_ff @(posedge clock) begin
                if (reset) begin
                    slot_reg <= '0;
                end else if (salva_aqui) begin
                    slot_reg <= salva_dado;
                end else if (escreve_aqui) begin
                    slot_reg <= escreve_dado;
                end
            end

            assign slots[gi] = slot_reg;
        end
    endgenerate

    // NUM_PROCESSOS is a power of two, so every le_id is in range
    assign le_dado = slots[le_id];

endmodule

// File: rtl/contador_programa.sv
// contador_programa
// Program counter with process context switching.
// Ports:
//   clock, reset          : clock and synchronous active-high reset
//   endereco_entrada      : next address from the mux
//   halt                  : halt retired -> PARADO until reset
//   troca_contexto        : single-cycle switch request, with id_processo_novo
//   escreve_pc_inicial    : OS write of pc_inicial into slot id_escrita
//   endereco_antigo       : current PC
//   endereco_instrucao    : PC + 1 (wrapping)
//   flag_pausa_contexto   : high while draining and during the switch cycle
//   id_processo_atual     : running process
//   processador_parado    : high in PARADO
module contador_programa
    import processador_pkg::*;
#(
    parameter int NUM_PROCESSOS = 8,
    parameter int PID_W         = $clog2(NUM_PROCESSOS),
    parameter int PAUSA_CICLOS  = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] endereco_entrada,
    input  logic              halt,
    input  logic              troca_contexto,
    input  logic [PID_W-1:0]  id_processo_novo,
    input  logic              escreve_pc_inicial,
    input  logic [PID_W-1:0]  id_escrita,
    input  logic [ADDR_W-1:0] pc_inicial,
    output logic [ADDR_W-1:0] endereco_antigo,
    output logic [ADDR_W-1:0] endereco_instrucao,
    output logic              flag_pausa_contexto,
    output logic [PID_W-1:0]  id_processo_atual,
    output logic              processador_parado
);

    localparam int CONT_W = (PAUSA_CICLOS > 1) ? $clog2(PAUSA_CICLOS) : 1;

    estado_t           estado_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic [PID_W-1:0]  atual_reg;
    logic [PID_W-1:0]  novo_reg;
    logic [CONT_W-1:0] cont_reg;
    logic              flag_reg;
    logic              parado_reg;

    logic              salva_en;
    logic              escreve_en;
    logic [ADDR_W-1:0] pc_salvo;

    // Save happens in the switch cycle; the OS write is blocked only in PARADO
    // (same-slot conflicts in TROCANDO are resolved inside the table).
    assign salva_en   = (estado_reg == TROCANDO);
    assign escreve_en = escreve_pc_inicial && (estado_reg != PARADO);

    tabela_contexto #(
        .NUM_PROCESSOS (NUM_PROCESSOS),
        .PID_W         (PID_W)
    ) u_tabela (
        .clock        (clock),
        .reset        (reset),
        .salva_en     (salva_en),
        .salva_id     (atual_reg),
        .salva_dado   (pc_reg),
        .escreve_en   (escreve_en),
        .escreve_id   (id_escrita),
        .escreve_dado (pc_inicial),
        .le_id        (novo_reg),
        .le_dado      (pc_salvo)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_reg <= EXECUTANDO;
            pc_reg     <= '0;
            atual_reg  <= '0;
            novo_reg   <= '0;
            cont_reg   <= '0;
            flag_reg   <= 1'b0;
            parado_reg <= 1'b0;
        end else begin
            case (estado_reg)
                EXECUTANDO: begin
                    if (halt) begin
                        estado_reg <= PARADO;
                        parado_reg <= 1'b1;
                    end else if (troca_contexto) begin
                        // The address presented now is the resume address
                        pc_reg     <= endereco_entrada;
                        novo_reg   <= id_processo_novo;
                        cont_reg   <= CONT_W'(PAUSA_CICLOS - 1);
                        estado_reg <= DRENANDO;
                        flag_reg   <= 1'b1;
                    end else begin
                        pc_reg <= endereco_entrada;
                    end
                end
                DRENANDO: begin
                    if (cont_reg == '0) begin
                        estado_reg <= TROCANDO;
                    end else begin
                        cont_reg <= cont_reg - CONT_W'(1);
                    end
                end
                TROCANDO: begin
                    // Same-process switch: the table still holds a stale value
                    // for this slot, so keep the live PC instead.
                    if (novo_reg != atual_reg) begin
                        pc_reg <= pc_salvo;
                    end
                    atual_reg  <= novo_reg;
                    estado_reg <= EXECUTANDO;
                    flag_reg   <= 1'b0;
                end
                default: begin
                    // PARADO: frozen until reset
                end
            endcase
        end
    end

    assign endereco_antigo     = pc_reg;
    assign endereco_instrucao  = incrementa_endereco(pc_reg);
    assign flag_pausa_contexto = flag_reg;
    assign id_processo_atual   = atual_reg;
    assign processador_parado  = parado_reg;

endmodule

// File: tb/tb_contador_programa.sv
// tb_contador_programa
// Directed stimulus; each step pushes its hand-computed expected outputs into
// a scoreboard queue, and an independent monitor pops and checks them on the
// falling edge after the clock edge that consumes the step's inputs.
module tb_contador_programa;

    localparam int NP = 8;
    localparam int PW = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] endereco_entrada = '0;
    logic        halt = 1'b0;
    logic        troca_contexto = 1'b0;
    logic [PW-1:0] id_processo_novo = '0;
    logic        escreve_pc_inicial = 1'b0;
    logic [PW-1:0] id_escrita = '0;
    logic [31:0] pc_inicial = '0;
    logic [31:0] endereco_antigo;
    logic [31:0] endereco_instrucao;
    logic        flag_pausa_contexto;
    logic [PW-1:0] id_processo_atual;
    logic        processador_parado;

    contador_programa #(
        .NUM_PROCESSOS (NP),
        .PID_W         (PW),
        .PAUSA_CICLOS  (3)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .endereco_entrada    (endereco_entrada),
        .halt                (halt),
        .troca_contexto      (troca_contexto),
        .id_processo_novo    (id_processo_novo),
        .escreve_pc_inicial  (escreve_pc_inicial),
        .id_escrita          (id_escrita),
        .pc_inicial          (pc_inicial),
        .endereco_antigo     (endereco_antigo),
        .endereco_instrucao  (endereco_instrucao),
        .flag_pausa_contexto (flag_pausa_contexto),
        .id_processo_atual   (id_processo_atual),
        .processador_parado  (processador_parado)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          ciclo;
        int          passo;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        flag;
        logic [PW-1:0] atual;
        logic        parado;
    } esperado_t;

    esperado_t fila[$];
    int ciclo = 0;
    int n_passo = 0;
    int n_assert = 0;
    int n_falhas = 0;
    bit estimulo_fim = 1'b0;

    always @(posedge clock) ciclo++;

    task automatic verifica(input string nome, input int passo, input logic [31:0] atual_v,
                            input logic [31:0] req_v);
        n_assert++;
        if (atual_v !== req_v) begin
            n_falhas++;
            $display("FAIL step %0d %s: got 0x%08h expected 0x%08h", passo, nome, atual_v, req_v);
        end
    endtask

    // Monitor: compare every expectation scheduled for the current cycle
    always @(negedge clock) begin
        while (fila.size() > 0 && fila[0].ciclo <= ciclo) begin
            esperado_t e;
            e = fila.pop_front();
            if (e.ciclo < ciclo) begin
                n_assert++;
                n_falhas++;
                $display("FAIL step %0d missed: checked at cycle %0d expected cycle %0d",
                         e.passo, ciclo, e.ciclo);
            end else begin
                verifica("endereco_antigo", e.passo, endereco_antigo, e.pc);
                verifica("endereco_instrucao", e.passo, endereco_instrucao, e.inst);
                verifica("flag_pausa", e.passo, 32'(flag_pausa_contexto), 32'(e.flag));
                verifica("id_atual", e.passo, 32'(id_processo_atual), 32'(e.atual));
                verifica("parado", e.passo, 32'(processador_parado), 32'(e.parado));
                $display("step %0d cyc %0d: pc=0x%08h inst=0x%08h flag=%0d atual=%0d parado=%0d",
                         e.passo, ciclo, endereco_antigo, endereco_instrucao,
                         flag_pausa_contexto, id_processo_atual, processador_parado);
            end
        end
    end

    // One cycle of stimulus plus the outputs expected after the consuming edge
    task automatic passo(input logic rst, input logic [31:0] ent, input logic hlt,
                         input logic trc, input logic [PW-1:0] idn,
                         input logic esc, input logic [PW-1:0] ide, input logic [31:0] pci,
                         input logic [31:0] e_pc, input logic [31:0] e_inst,
                         input logic e_flag, input logic [PW-1:0] e_atual, input logic e_parado);
        esperado_t e;
        @(posedge clock);
        #1;
        reset              = rst;
        endereco_entrada   = ent;
        halt               = hlt;
        troca_contexto     = trc;
        id_processo_novo   = idn;
        escreve_pc_inicial = esc;
        id_escrita         = ide;
        pc_inicial         = pci;
        n_passo++;
        e.ciclo  = ciclo + 1;
        e.passo  = n_passo;
        e.pc     = e_pc;
        e.inst   = e_inst;
        e.flag   = e_flag;
        e.atual  = e_atual;
        e.parado = e_parado;
        fila.push_back(e);
    endtask

    initial begin
        // Reset state
        passo(1, 32'h0,   0, 0, 0, 0, 0, 0,       32'h0,   32'h1,   0, 0, 0);
        // Sequential feed, one cycle latency
        passo(0, 32'h10,  0, 0, 0, 0, 0, 0,       32'h10,  32'h11,  0, 0, 0);
        passo(0, 32'h11,  0, 0, 0, 0, 0, 0,       32'h11,  32'h12,  0, 0, 0);
        passo(0, 32'h40,  0, 0, 0, 0, 0, 0,       32'h40,  32'h41,  0, 0, 0);
        // Slot 2 = 0x200, run at 0x55, switch to 2
        passo(0, 32'h41,  0, 0, 0, 1, 2, 32'h200, 32'h41,  32'h42,  0, 0, 0);
        passo(0, 32'h55,  0, 0, 0, 0, 0, 0,       32'h55,  32'h56,  0, 0, 0);
        passo(0, 32'h55,  0, 1, 2, 0, 0, 0,       32'h55,  32'h56,  1, 0, 0);
        passo(0, 32'h999, 1, 0, 0, 0, 0, 0,       32'h55,  32'h56,  1, 0, 0);
        passo(0, 32'h998, 0, 1, 5, 0, 0, 0,       32'h55,  32'h56,  1, 0, 0);
        passo(0, 32'h997, 0, 0, 0, 0, 0, 0,       32'h55,  32'h56,  1, 0, 0);
        passo(0, 32'h996, 0, 0, 0, 0, 0, 0,       32'h200, 32'h201, 0, 2, 0);
        passo(0, 32'h201, 0, 0, 0, 0, 0, 0,       32'h201, 32'h202, 0, 2, 0);
        // Back to 0 (slot 0 holds 0x55); conflicting write to slot 2 in TROCANDO ignored
        passo(0, 32'h300, 0, 1, 0, 0, 0, 0,       32'h300, 32'h301, 1, 2, 0);
        passo(0, 32'h1,   0, 0, 0, 0, 0, 0,       32'h300, 32'h301, 1, 2, 0);
        passo(0, 32'h2,   0, 0, 0, 0, 0, 0,       32'h300, 32'h301, 1, 2, 0);
        passo(0, 32'h3,   0, 0, 0, 0, 0, 0,       32'h300, 32'h301, 1, 2, 0);
        passo(0, 32'h4,   0, 0, 0, 1, 2, 32'hBAD, 32'h55,  32'h56,  0, 0, 0);
        // Wrap boundary
        passo(0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0,  32'hFFFFFFFF, 32'h0, 0, 0, 0);
        // Slot 1 = 0x80, switch to 1
        passo(0, 32'h60,  0, 0, 0, 1, 1, 32'h80,  32'h60,  32'h61,  0, 0, 0);
        passo(0, 32'h61,  0, 1, 1, 0, 0, 0,       32'h61,  32'h62,  1, 0, 0);
        passo(0, 32'h5,   0, 0, 0, 0, 0, 0,       32'h61,  32'h62,  1, 0, 0);
        passo(0, 32'h6,   0, 0, 0, 0, 0, 0,       32'h61,  32'h62,  1, 0, 0);
        passo(0, 32'h7,   0, 0, 0, 0, 0, 0,       32'h61,  32'h62,  1, 0, 0);
        passo(0, 32'h8,   0, 0, 0, 0, 0, 0,       32'h80,  32'h81,  0, 1, 0);
        // Same-PID switch at 0x80: PC stays 0x80, write to own slot ignored
        passo(0, 32'h80,  0, 1, 1, 0, 0, 0,       32'h80,  32'h81,  1, 1, 0);
        passo(0, 32'h123, 0, 0, 0, 0, 0, 0,       32'h80,  32'h81,  1, 1, 0);
        passo(0, 32'h124, 0, 0, 0, 0, 0, 0,       32'h80,  32'h81,  1, 1, 0);
        passo(0, 32'h125, 0, 0, 0, 0, 0, 0,       32'h80,  32'h81,  1, 1, 0);
        passo(0, 32'h126, 0, 0, 0, 1, 1, 32'h777, 32'h80,  32'h81,  0, 1, 0);
        // Switch to 2: saved 0x300 survived the conflicting write
        passo(0, 32'h90,  0, 1, 2, 0, 0, 0,       32'h90,  32'h91,  1, 1, 0);
        passo(0, 32'h9,   0, 0, 0, 0, 0, 0,       32'h90,  32'h91,  1, 1, 0);
        passo(0, 32'hA,   0, 0, 0, 0, 0, 0,       32'h90,  32'h91,  1, 1, 0);
        passo(0, 32'hB,   0, 0, 0, 0, 0, 0,       32'h90,  32'h91,  1, 1, 0);
        passo(0, 32'hC,   0, 0, 0, 0, 0, 0,       32'h300, 32'h301, 0, 2, 0);
        // halt + troca together -> PARADO, PC frozen, requests ignored
        passo(0, 32'h301, 1, 1, 5, 0, 0, 0,       32'h300, 32'h301, 0, 2, 1);
        passo(0, 32'h999, 0, 1, 3, 1, 3, 32'h33,  32'h300, 32'h301, 0, 2, 1);
        passo(0, 32'h5,   1, 0, 0, 0, 0, 0,       32'h300, 32'h301, 0, 2, 1);
        passo(1, 32'h0,   0, 0, 0, 0, 0, 0,       32'h0,   32'h1,   0, 0, 0);
        // Reset during DRENANDO clears everything including slot 3
        passo(0, 32'h70,  0, 0, 0, 1, 3, 32'h333, 32'h70,  32'h71,  0, 0, 0);
        passo(0, 32'h71,  0, 1, 3, 0, 0, 0,       32'h71,  32'h72,  1, 0, 0);
        passo(0, 32'h72,  0, 0, 0, 0, 0, 0,       32'h71,  32'h72,  1, 0, 0);
        passo(1, 32'h73,  0, 0, 0, 0, 0, 0,       32'h0,   32'h1,   0, 0, 0);
        passo(0, 32'h10,  0, 1, 3, 0, 0, 0,       32'h10,  32'h11,  1, 0, 0);
        passo(0, 32'hD,   0, 0, 0, 0, 0, 0,       32'h10,  32'h11,  1, 0, 0);
        passo(0, 32'hE,   0, 0, 0, 0, 0, 0,       32'h10,  32'h11,  1, 0, 0);
        passo(0, 32'hF,   0, 0, 0, 0, 0, 0,       32'h10,  32'h11,  1, 0, 0);
        passo(0, 32'h20,  0, 0, 0, 0, 0, 0,       32'h0,   32'h1,   0, 3, 0);
        // Slot 2 also cleared
        passo(0, 32'h21,  0, 1, 2, 0, 0, 0,       32'h21,  32'h22,  1, 3, 0);
        passo(0, 32'h22,  0, 0, 0, 0, 0, 0,       32'h21,  32'h22,  1, 3, 0);
        passo(0, 32'h23,  0, 0, 0, 0, 0, 0,       32'h21,  32'h22,  1, 3, 0);
        passo(0, 32'h24,  0, 0, 0, 0, 0, 0,       32'h21,  32'h22,  1, 3, 0);
        passo(0, 32'h25,  0, 0, 0, 0, 0, 0,       32'h0,   32'h1,   0, 2, 0);
        @(posedge clock);
        #1;
        troca_contexto     = 1'b0;
        escreve_pc_inicial = 1'b0;
        estimulo_fim = 1'b1;
    end

    initial begin
        int espera;
        wait (estimulo_fim);
        espera = 0;
        while (fila.size() > 0 && espera < 20) begin
            @(posedge clock);
            espera++;
        end
        @(posedge clock);
        if (fila.size() > 0) begin
            n_assert++;
            n_falhas++;
            $display("FAIL drain: %0d expectations left, required 0", fila.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_falhas);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

endmodule
